// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer.
// Owns the PC. Issues single-outstanding req/ack reads to instruction memory
// and hands fetched words to the IF/ID register. Handles hazard freeze through
// a one-entry skid, branch redirects, and squashing of an in-flight fetch.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   freeze       IF/ID cannot accept a word this cycle
//   Br_taken     one-cycle redirect request (beats freeze)
//   Br_target    redirect byte address; bits [1:0] ignored
//   mem_req      fetch request to instruction memory
//   mem_addr     word-aligned fetch address, stable until acked
//   mem_ack      memory returns mem_rdata this cycle
//   mem_rdata    fetched instruction word
//   if_valid     instruction/if_pc hold a live instruction
//   if_pc        address of the word in instruction
//   instruction  fetched instruction word
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] instruction
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;

  logic [31:0] br_pc;
  logic        slot_ld;
  logic        acked;

  assign br_pc   = {Br_target[31:2], 2'b00};
  assign slot_ld = !if_valid || !freeze;
  assign acked   = mem_req && mem_ack;

  // pc tracks mem_addr except while a squashed request is still in flight;
  // then mem_addr holds the abandoned address and pc already holds the
  // redirect target, which is issued once the dropped response returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      instruction <= '0;
    end else if (Br_taken) begin
      if_valid <= 1'b0;
      pc       <= br_pc;
      if (state == FETCH && mem_req && !mem_ack) begin
        // Request must finish at its original address; drop its data later.
        squash <= 1'b1;
      end else begin
        squash   <= 1'b0;
        state    <= FETCH;
        mem_req  <= 1'b1;
        mem_addr <= br_pc;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end
        FETCH: begin
          if (acked) begin
            if (squash) begin
              squash   <= 1'b0;
              mem_addr <= pc;
              if (slot_ld) if_valid <= 1'b0;
            end else if (slot_ld) begin
              instruction <= mem_rdata;
              if_pc       <= pc;
              if_valid    <= 1'b1;
              pc          <= pc + 32'd4;
              mem_addr    <= pc + 32'd4;
            end else begin
              skid_data <= mem_rdata;
              skid_pc   <= pc;
              pc        <= pc + 32'd4;
              mem_req   <= 1'b0;
              state     <= HOLD;
            end
          end else if (slot_ld) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            instruction <= skid_data;
            if_pc       <= skid_pc;
            if_valid    <= 1'b1;
            state       <= FETCH;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and randomized bench for fetch_controller.
// The reference is a consumption-stream model: every word taken by IF/ID
// (if_valid=1, freeze=0) must be the next sequential address, restarting at
// the aligned target after each Br_taken, carrying addr^K as its data.
// Protocol properties (address stability, flush, freeze hold) are checked
// alongside. A second instance covers a non-zero RESET_PC and wrap-around.
module tb_fetch_controller;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A, RESET_PC = 0
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        Br_taken = 1'b0;
  logic [31:0] Br_target = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] instruction;

  // Instance B, RESET_PC = 0xFFFFFFF8
  logic        rst_b = 1'b0;
  logic        freeze_b = 1'b0;
  logic        br_b = 1'b0;
  logic [31:0] tgt_b = '0;
  logic        ack_b_en = 1'b0;
  logic        mem_req_b;
  logic [31:0] mem_addr_b;
  logic        mem_ack_b;
  logic [31:0] mem_rdata_b;
  logic        if_valid_b;
  logic [31:0] if_pc_b;
  logic [31:0] instruction_b;

  assign mem_ack_b   = ack_b_en & mem_req_b;
  assign mem_rdata_b = mem_addr_b ^ K;

  fetch_controller #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Br_taken(Br_taken),
    .Br_target(Br_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .instruction(instruction)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .freeze(freeze_b), .Br_taken(br_b),
    .Br_target(tgt_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .if_valid(if_valid_b),
    .if_pc(if_pc_b), .instruction(instruction_b)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc = '0;
  int consumed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of instance A. Called just after a rising edge; drives inputs,
  // runs the stream model for the coming edge, then checks after it.
  task automatic cyc(input logic fr, input logic br, input logic [31:0] tg, input logic ack);
    logic        pre_req;
    logic [31:0] pre_addr;
    logic        pre_ack;
    logic        hold;
    logic [31:0] pre_pc;
    logic [31:0] pre_ins;
    freeze    = fr;
    Br_taken  = br;
    Br_target = tg;
    mem_ack   = ack & mem_req;
    mem_rdata = mem_addr ^ K;
    pre_req  = mem_req;
    pre_addr = mem_addr;
    pre_ack  = mem_ack;
    if (mem_req) chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
    if (if_valid && !fr) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_ins", instruction, exp_pc ^ K);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    hold    = if_valid && fr && !br;
    pre_pc  = if_pc;
    pre_ins = instruction;
    if (br) exp_pc = {tg[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (pre_req && !pre_ack) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, pre_addr);
    end
    if (br) chk("br_flush", {31'd0, if_valid}, 32'd0);
    if (hold) begin
      chk("frz_valid", {31'd0, if_valid}, 32'd1);
      chk("frz_pc", if_pc, pre_pc);
      chk("frz_ins", instruction, pre_ins);
    end
  endtask

  initial begin
    // Reset values of A
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_ins", instruction, 32'd0);
    exp_pc = 32'd0;
    rst = 1'b1;

    // Zero-wait start-up: 0 then 4
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr0", mem_addr, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t1_addr4", mem_addr, 32'd4);
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc", if_pc, 32'd0);

    // Ack at 0x4 delayed three cycles, then a single pulse
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0);
      chk("t2_addr", mem_addr, 32'd4);
      chk("t2_novalid", {31'd0, if_valid}, 32'd0);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t2_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_pc", if_pc, 32'd4);

    // Freeze while 0x8 valid: 0xC parks in the skid
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t3_pc8", if_pc, 32'd8);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b1);
      chk("t3_noreq", {31'd0, mem_req}, 32'd0);
      chk("t3_hold", if_pc, 32'd8);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t3_pcC", if_pc, 32'hC);
    chk("t3_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_req10", mem_addr, 32'h10);

    // Redirect to 0x40 while 0x10 outstanding, ack two cycles later
    cyc(1'b0, 1'b1, 32'h40, 1'b0);
    chk("t4_addr", mem_addr, 32'h10);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_addr2", mem_addr, 32'h10);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t4_drop", {31'd0, if_valid}, 32'd0);
    chk("t4_req40", mem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t4_pc40", if_pc, 32'h40);
    chk("t4_ins40", instruction, 32'h40 ^ K);

    // Redirect, freeze and ack in one cycle, unaligned target
    cyc(1'b1, 1'b1, 32'h43, 1'b1);
    chk("t5_req40", mem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t5_valid", {31'd0, if_valid}, 32'd1);
    chk("t5_pc40", if_pc, 32'h40);

    // Randomized traffic against the stream model
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom, ($urandom % 2) == 1);
    end
    chk("progress", {31'd0, consumed > 200}, 32'd1);

    // Instance B: wrap-around and reset during a wait
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_rst_addr", mem_addr_b, 32'hFFFF_FFF8);
    chk("b_rst_req", {31'd0, mem_req_b}, 32'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_addr0", mem_addr_b, 32'hFFFF_FFF8);
    ack_b_en = 1'b1;
    @(posedge clk);
    #1;
    chk("b_addr1", mem_addr_b, 32'hFFFF_FFFC);
    chk("b_pc0", if_pc_b, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    chk("b_wrap", mem_addr_b, 32'h0);
    chk("b_pc1", if_pc_b, 32'hFFFF_FFFC);
    chk("b_ins1", instruction_b, 32'hFFFF_FFFC ^ K);
    ack_b_en = 1'b0;
    @(posedge clk);
    #1;
    chk("b_wait_req", {31'd0, mem_req_b}, 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("b_async_req", {31'd0, mem_req_b}, 32'd0);
    chk("b_async_valid", {31'd0, if_valid_b}, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_refetch_req", {31'd0, mem_req_b}, 32'd1);
    chk("b_refetch_addr", mem_addr_b, 32'hFFFF_FFF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
